// File: rtl/conv_pkg.sv
// Shared helpers for the KxK convolution MAC: accumulator sizing,
// tap indexing, rounding right-shift and signed saturation.
// Arithmetic helpers work on a wide signed container so one definition
// serves every parameterisation; callers narrow the result themselves.
package conv_pkg;

  localparam int unsigned CalcW = 64;

  typedef logic signed [CalcW-1:0] calc_t;

  // Accumulator width that cannot overflow for K*K full-scale products.
  function automatic int unsigned acc_width(int unsigned k, int unsigned dw, int unsigned ww);
    return dw + ww + 1 + $clog2(k * k);
  endfunction

  // LSB of tap t inside a flat bus of w-bit lanes.
  function automatic int unsigned tap_lsb(int unsigned t, int unsigned w);
    return t * w;
  endfunction

  // Round-half-up arithmetic right shift. Shifts at or beyond the
  // accumulator width collapse to the sign (0 or -1).
  function automatic calc_t round_shift(calc_t v, int unsigned sh, int unsigned acc_w);
    calc_t half;
    if (sh == 0) begin
      return v;
    end
    if (sh >= acc_w) begin
      return v[CalcW-1] ? '1 : '0;
    end
    half = calc_t'(1) <<< (sh - 1);
    return (v + half) >>> sh;
  endfunction

  // Clamp to the signed ow-bit range.
  function automatic calc_t saturate(calc_t v, int unsigned ow);
    calc_t hi;
    calc_t lo;
    hi = (calc_t'(1) <<< (ow - 1)) - calc_t'(1);
    lo = -(calc_t'(1) <<< (ow - 1));
    if (v > hi) begin
      return hi;
    end
    if (v < lo) begin
      return lo;
    end
    return v;
  endfunction

endpackage

// File: rtl/conv_mac_pipe_if.sv
// Handshake/config bundle for conv_mac_pipe. The master side (window
// generator + controller) drives windows and config; the slave side is
// the MAC pipeline.
interface conv_mac_pipe_if #(
  parameter int unsigned K   = 3,
  parameter int unsigned DW  = 8,
  parameter int unsigned WW  = 8,
  parameter int unsigned BW  = 16,
  parameter int unsigned OW  = 8,
  parameter int unsigned SHW = 5
);

  logic                i_cfg_load;
  logic [K*K*WW-1:0]   i_weight;
  logic [BW-1:0]       i_bias;
  logic [SHW-1:0]      i_shift;
  logic                o_cfg_ready;
  logic [K*K*DW-1:0]   i_pixel_data;
  logic                i_pixel_data_valid;
  logic                o_pixel_ready;
  logic [OW-1:0]       o_convolved_data;
  logic                o_convolved_valid;
  logic                i_out_ready;

  modport master (
    output i_cfg_load, i_weight, i_bias, i_shift,
    output i_pixel_data, i_pixel_data_valid, i_out_ready,
    input  o_cfg_ready, o_pixel_ready, o_convolved_data, o_convolved_valid
  );

  modport slave (
    input  i_cfg_load, i_weight, i_bias, i_shift,
    input  i_pixel_data, i_pixel_data_valid, i_out_ready,
    output o_cfg_ready, o_pixel_ready, o_convolved_data, o_convolved_valid
  );

endinterface

// File: rtl/conv_adder_tree.sv
// Registered signed reduction of N products into one accumulator-width
// sum. One pipeline stage; holds its contents while en_i is low.
module conv_adder_tree
  import conv_pkg::*;
#(
  parameter int unsigned N  = 9,
  parameter int unsigned PW = 17,
  parameter int unsigned AW = 21
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 en_i,
  input  logic                 valid_i,
  input  logic [N*PW-1:0]      prod_i,
  output logic                 valid_o,
  output logic signed [AW-1:0] sum_o
);

  logic                 valid_q, valid_d;
  logic signed [AW-1:0] sum_q, sum_d;
  logic signed [AW-1:0] tree;

  // Sign-extend every product and add them up
  always_comb begin
    tree = '0;
    for (int unsigned t = 0; t < N; t++) begin
      tree = tree + AW'($signed(prod_i[tap_lsb(t, PW) +: PW]));
    end
  end

  // Advance only when the pipeline is not stalled
  always_comb begin
    valid_d = valid_q;
    sum_d   = sum_q;
    if (en_i) begin
      valid_d = valid_i;
      sum_d   = tree;
    end
  end

  // Stage register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      sum_q   <= '0;
    end else begin
      valid_q <= valid_d;
      sum_q   <= sum_d;
    end
  end

  assign valid_o = valid_q;
  assign sum_o   = sum_q;

endmodule

// File: rtl/conv_mac_pipe.sv
// KxK convolution MAC: multiply -> adder tree -> bias/round/saturate.
// Three register stages, one window per cycle, whole-pipe stall when the
// output is held. Config bank loads only while the pipe is empty.
// Build option: define CONV_RELU_EN to clamp negative results to zero.
module conv_mac_pipe
  import conv_pkg::*;
#(
  parameter int unsigned K   = 3,
  parameter int unsigned DW  = 8,
  parameter int unsigned WW  = 8,
  parameter int unsigned BW  = 16,
  parameter int unsigned OW  = 8,
  parameter int unsigned SHW = 5
) (
  input logic            i_clk,
  input logic            i_rst,
  conv_mac_pipe_if.slave bus
);

  localparam int unsigned N     = K * K;
  localparam int unsigned PW    = DW + WW + 1;
  localparam int unsigned ACC_W = acc_width(K, DW, WW);

  logic stall;
  logic accept;
  logic cfg_do;

  logic [N*WW-1:0]  weight_q, weight_d;
  logic [BW-1:0]    bias_q, bias_d;
  logic [SHW-1:0]   shift_q, shift_d;

  logic             s1_valid_q, s1_valid_d;
  logic [N*PW-1:0]  prod_q, prod_d;

  logic                    s2_valid;
  logic signed [ACC_W-1:0] s2_sum;

  logic             out_valid_q, out_valid_d;
  logic [OW-1:0]    out_data_q, out_data_d;

  logic signed [ACC_W-1:0] biased;
  calc_t                   rounded;
  logic signed [OW-1:0]    clamped;
  logic [OW-1:0]           result;

  // A held output freezes every stage, so no bubble is ever squeezed out
  assign stall             = out_valid_q & ~bus.i_out_ready;
  assign bus.o_pixel_ready = ~stall & ~bus.i_cfg_load;
  assign accept            = bus.i_pixel_data_valid & bus.o_pixel_ready;
  assign bus.o_cfg_ready   = ~(s1_valid_q | s2_valid | out_valid_q);
  assign cfg_do            = bus.i_cfg_load & bus.o_cfg_ready;

  // Config bank next state
  always_comb begin
    weight_d = weight_q;
    bias_d   = bias_q;
    shift_d  = shift_q;
    if (cfg_do) begin
      weight_d = bus.i_weight;
      bias_d   = bus.i_bias;
      shift_d  = bus.i_shift;
    end
  end

  // Stage 1: per-tap unsigned pixel x signed weight
  always_comb begin
    s1_valid_d = s1_valid_q;
    prod_d     = prod_q;
    if (!stall) begin
      s1_valid_d = accept;
      if (accept) begin
        for (int unsigned t = 0; t < N; t++) begin
          prod_d[tap_lsb(t, PW) +: PW] =
            PW'($signed({1'b0, bus.i_pixel_data[tap_lsb(t, DW) +: DW]})) *
            PW'($signed(weight_q[tap_lsb(t, WW) +: WW]));
        end
      end
    end
  end

  // Stage 2 lives in the adder tree
  conv_adder_tree #(
    .N  (N),
    .PW (PW),
    .AW (ACC_W)
  ) u_tree (
    .clk_i   (i_clk),
    .rst_ni  (i_rst),
    .en_i    (~stall),
    .valid_i (s1_valid_q),
    .prod_i  (prod_q),
    .valid_o (s2_valid),
    .sum_o   (s2_sum)
  );

  // Stage 3 datapath: bias, round-shift, saturate, optional ReLU
  always_comb begin
    biased  = s2_sum + ACC_W'($signed(bias_q));
    rounded = round_shift(calc_t'(biased), 32'(shift_q), ACC_W);
    clamped = OW'(saturate(rounded, OW));
    result  = clamped;
`ifdef CONV_RELU_EN
    if (clamped[OW-1]) begin
      result = '0;
    end
`else
`endif
  end

  // Output register next state; data only moves with a valid result
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    if (!stall) begin
      out_valid_d = s2_valid;
      if (s2_valid) begin
        out_data_d = result;
      end
    end
  end

  // All pipeline and bank state
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      weight_q    <= '0;
      bias_q      <= '0;
      shift_q     <= '0;
      s1_valid_q  <= 1'b0;
      prod_q      <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      weight_q    <= weight_d;
      bias_q      <= bias_d;
      shift_q     <= shift_d;
      s1_valid_q  <= s1_valid_d;
      prod_q      <= prod_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign bus.o_convolved_valid = out_valid_q;
  assign bus.o_convolved_data  = out_data_q;

endmodule
